// File: rtl/sgf_addsub_stage.sv
// Two-stage significand adder/subtractor for the fpaddsub datapath.
// Stage 1 forms the raw (W+1)-bit sum/difference; stage 2 fixes magnitude, sign, carry and zero.
module sgf_addsub_stage #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         eff_op_i,
  input  logic         sign_a_i,
  input  logic [W-1:0] sgf_a_i,
  input  logic [W-1:0] sgf_b_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] sgf_r_o,
  output logic         carry_o,
  output logic         sign_r_o,
  output logic         zero_o
);

  logic         s1_valid_q, s1_valid_d;
  logic [W:0]   s1_t_q, s1_t_d;
  logic         s1_op_q, s1_op_d;
  logic         s1_sign_q, s1_sign_d;

  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_r_q, s2_r_d;
  logic         s2_carry_q, s2_carry_d;
  logic         s2_sign_q, s2_sign_d;
  logic         s2_zero_q, s2_zero_d;

  logic         s1_ready, s2_ready;
  logic         s1_load, s2_load;
  logic         borrow;

  assign s2_ready = !s2_valid_q || ready_i;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s1_load  = valid_i && s1_ready;
  assign s2_load  = s1_valid_q && s2_ready;
  assign ready_o  = s1_ready;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_t_d     = s1_t_q;
    s1_op_d    = s1_op_q;
    s1_sign_d  = s1_sign_q;
    if (s1_ready) s1_valid_d = valid_i;
    if (s1_load) begin
      s1_t_d    = eff_op_i ? ({1'b0, sgf_a_i} - {1'b0, sgf_b_i})
                           : ({1'b0, sgf_a_i} + {1'b0, sgf_b_i});
      s1_op_d   = eff_op_i;
      s1_sign_d = sign_a_i;
    end
  end

  // A borrow means B > A: negate the difference and flip the sign.
  // Exact cancellation in a subtract always yields +0.
  assign borrow = s1_op_q && s1_t_q[W];

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_r_d     = s2_r_q;
    s2_carry_d = s2_carry_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    if (s2_ready) s2_valid_d = s1_valid_q;
    if (s2_load) begin
      s2_r_d     = borrow ? (~s1_t_q[W-1:0] + W'(1)) : s1_t_q[W-1:0];
      s2_carry_d = !s1_op_q && s1_t_q[W];
      if (s1_op_q && (s1_t_q == '0)) s2_sign_d = 1'b0;
      else if (borrow)               s2_sign_d = !s1_sign_q;
      else                           s2_sign_d = s1_sign_q;
      s2_zero_d  = (s2_r_d == '0) && !s2_carry_d;
    end
  end

  // NOTE: datapath registers are reset too, because the outputs must read 0 during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_t_q     <= '0;
      s1_op_q    <= 1'b0;
      s1_sign_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
      s2_carry_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep both stages updating from pre-edge values.
      s1_valid_q <= s1_valid_d;
      s1_t_q     <= s1_t_d;
      s1_op_q    <= s1_op_d;
      s1_sign_q  <= s1_sign_d;
      s2_valid_q <= s2_valid_d;
      s2_r_q     <= s2_r_d;
      s2_carry_q <= s2_carry_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign valid_o  = s2_valid_q;
  assign sgf_r_o  = s2_r_q;
  assign carry_o  = s2_carry_q;
  assign sign_r_o = s2_sign_q;
  assign zero_o   = s2_zero_q;

endmodule

// File: tb/tb_sgf_addsub_stage.sv
// Bench for sgf_addsub_stage at W=8: directed vector table, reset, backpressure and random streaming,
// with expected results queued on input transfer and compared on output transfer.
module tb_sgf_addsub_stage;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         s;
    logic         z;
  } res_t;

  typedef struct packed {
    logic         op;
    logic         sa;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i, ready_o, eff_op_i, sign_a_i;
  logic [W-1:0] sgf_a_i, sgf_b_i;
  logic         valid_o, ready_i;
  logic [W-1:0] sgf_r_o;
  logic         carry_o, sign_r_o, zero_o;

  sgf_addsub_stage #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .ready_o(ready_o),
    .eff_op_i(eff_op_i), .sign_a_i(sign_a_i),
    .sgf_a_i(sgf_a_i), .sgf_b_i(sgf_b_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .sgf_r_o(sgf_r_o), .carry_o(carry_o),
    .sign_r_o(sign_r_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  res_t sb_q[$];
  res_t exp_cur;
  res_t stall_snap;
  bit   stall_prev = 0;
  int   n_out = 0;
  int   run = 0;
  int   max_run = 0;
  bit   saw_rdy_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic res_t model(input logic op, input logic sa, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t   m;
    int     ia, ib, d;
    ia = int'(a);
    ib = int'(b);
    if (!op) begin
      d   = ia + ib;
      m.r = d[W-1:0];
      m.c = d >= (1 << W);
      m.s = sa;
    end else begin
      m.c = 1'b0;
      if (ia >= ib) begin d = ia - ib; m.s = (ia == ib) ? 1'b0 : sa; end
      else          begin d = ib - ia; m.s = !sa; end
      m.r = d[W-1:0];
    end
    m.z = (m.r == '0) && !m.c;
    return m;
  endfunction

  task automatic drive(input logic op, input logic sa, input logic [W-1:0] a,
                       input logic [W-1:0] b, input res_t e);
    valid_i  = 1'b1;
    eff_op_i = op;
    sign_a_i = sa;
    sgf_a_i  = a;
    sgf_b_i  = b;
    exp_cur  = e;
  endtask

  // One clock: sample at the falling edge, then advance to just after the rising edge.
  task automatic step(output bit accepted);
    res_t cur, e;
    @(negedge clk);
    cur = '{r: sgf_r_o, c: carry_o, s: sign_r_o, z: zero_o};
    if (stall_prev) check("stall_hold", 32'(cur), 32'(stall_snap));
    if (valid_o && !ready_i) begin stall_prev = 1; stall_snap = cur; end
    else stall_prev = 0;
    if (valid_o) begin run++; if (run > max_run) max_run = run; end
    else run = 0;
    if (!ready_o) saw_rdy_low = 1;
    if (valid_o && ready_i) begin
      n_out++;
      if (sb_q.size() == 0) check("unexpected_output", 32'(cur), 32'hFFFF_FFFF);
      else begin
        e = sb_q.pop_front();
        check("result", 32'(cur), 32'(e));
      end
    end
    accepted = valid_i && ready_o;
    if (accepted) sb_q.push_back(exp_cur);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int idx, base;
    vec_t bp[5];
    vec_t rv[16];

    vecs[0] = '{op:0, sa:1, a:8'h90, b:8'h80, exp:'{r:8'h10, c:1, s:1, z:0}};
    vecs[1] = '{op:1, sa:0, a:8'h30, b:8'h50, exp:'{r:8'h20, c:0, s:1, z:0}};
    vecs[2] = '{op:1, sa:0, a:8'h50, b:8'h30, exp:'{r:8'h20, c:0, s:0, z:0}};
    vecs[3] = '{op:1, sa:1, a:8'h7F, b:8'h7F, exp:'{r:8'h00, c:0, s:0, z:1}};
    vecs[4] = '{op:0, sa:1, a:8'h00, b:8'h00, exp:'{r:8'h00, c:0, s:1, z:1}};
    vecs[5] = '{op:0, sa:0, a:8'hFF, b:8'hFF, exp:'{r:8'hFE, c:1, s:0, z:0}};
    vecs[6] = '{op:0, sa:0, a:8'h80, b:8'h80, exp:'{r:8'h00, c:1, s:0, z:0}};
    vecs[7] = '{op:1, sa:1, a:8'h00, b:8'hFF, exp:'{r:8'hFF, c:0, s:0, z:0}};
    vecs[8] = '{op:1, sa:1, a:8'hFF, b:8'h00, exp:'{r:8'hFF, c:0, s:1, z:0}};
    vecs[9] = '{op:1, sa:1, a:8'h00, b:8'h00, exp:'{r:8'h00, c:0, s:0, z:1}};

    rst = 1'b0; valid_i = 0; ready_i = 1; eff_op_i = 0; sign_a_i = 0;
    sgf_a_i = '0; sgf_b_i = '0; exp_cur = '0; stall_snap = '0;
    #12;
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_outputs", 32'({sgf_r_o, carry_o, sign_r_o, zero_o}), 32'd0);
    check("reset_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed table, one op at a time, with exact-latency checks.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].sa, vecs[i].a, vecs[i].b, vecs[i].exp);
      step(acc);
      check("vec_accept", 32'(acc), 32'd1);
      valid_i = 0;
      check("vec_lat_not_early", 32'(valid_o), 32'd0);
      step(acc);
      check("vec_lat_two", 32'(valid_o), 32'd1);
      step(acc);
    end
    check("vec_all_drained", 32'(sb_q.size()), 32'd0);

    // Reset with two ops in flight.
    drive(0, 0, 8'h11, 8'h22, model(0, 0, 8'h11, 8'h22)); step(acc);
    drive(1, 1, 8'h40, 8'h10, model(1, 1, 8'h40, 8'h10)); step(acc);
    valid_i = 0;
    #2 rst = 1'b0;
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_outputs", 32'({sgf_r_o, carry_o, sign_r_o, zero_o}), 32'd0);
    sb_q.delete(); stall_prev = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    drive(1, 0, 8'h05, 8'h09, model(1, 0, 8'h05, 8'h09));
    step(acc);
    valid_i = 0;
    check("postrst_not_early", 32'(valid_o), 32'd0);
    step(acc);
    check("postrst_lat_two", 32'(valid_o), 32'd1);
    base = n_out;
    for (int k = 0; k < 4; k++) step(acc);
    check("postrst_one_out", 32'(n_out - base), 32'd1);
    check("postrst_drained", 32'(sb_q.size()), 32'd0);

    // Backpressure: 5 ops streamed, ready_i low for cycles 3..6.
    foreach (bp[i]) begin
      bp[i].op = 1'($urandom); bp[i].sa = 1'($urandom);
      bp[i].a = 8'($urandom); bp[i].b = 8'($urandom);
    end
    idx = 0; base = n_out; saw_rdy_low = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      ready_i = !(cyc >= 3 && cyc <= 6);
      if (idx < 5) drive(bp[idx].op, bp[idx].sa, bp[idx].a, bp[idx].b,
                         model(bp[idx].op, bp[idx].sa, bp[idx].a, bp[idx].b));
      else valid_i = 0;
      step(acc);
      if (acc) idx++;
    end
    ready_i = 1;
    check("bp_all_accepted", 32'(idx), 32'd5);
    check("bp_ready_dropped", 32'(saw_rdy_low), 32'd1);
    check("bp_five_out", 32'(n_out - base), 32'd5);
    check("bp_drained", 32'(sb_q.size()), 32'd0);

    // Full throughput: 16 random ops back-to-back.
    foreach (rv[i]) begin
      rv[i].op = 1'($urandom); rv[i].sa = 1'($urandom);
      rv[i].a = 8'($urandom_range(0, 255)); rv[i].b = 8'($urandom_range(0, 255));
    end
    rv[3].a = rv[3].b; rv[3].op = 1'b1;
    idx = 0; base = n_out; max_run = 0; saw_rdy_low = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (idx < 16) drive(rv[idx].op, rv[idx].sa, rv[idx].a, rv[idx].b,
                          model(rv[idx].op, rv[idx].sa, rv[idx].a, rv[idx].b));
      else valid_i = 0;
      step(acc);
      if (acc) idx++;
    end
    check("tp_accepted", 32'(idx), 32'd16);
    check("tp_never_stalled", 32'(saw_rdy_low), 32'd0);
    check("tp_consecutive", 32'(max_run), 32'd16);
    check("tp_out_count", 32'(n_out - base), 32'd16);
    check("tp_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
